// File: rtl/mips_pkg.sv
// Shared constants for the MIPS decode/execute slice: widths, ALU control
// codes, aluop and funct encodings, and the operand forwarding helper.
package mips_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_BAD = 4'b1111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // r0 is hard-wired zero, so it is never a forwarding target.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] rf_data,
    input logic              exmem_wr,
    input logic [IDX_W-1:0]  exmem_rd,
    input logic [DATA_W-1:0] exmem_res,
    input logic              memwb_wr,
    input logic [IDX_W-1:0]  memwb_rd,
    input logic [DATA_W-1:0] memwb_res
  );
    logic [DATA_W-1:0] r;
    r = rf_data;
    if (idx != '0) begin
      if (exmem_wr && (exmem_rd == idx))      r = exmem_res;
      else if (memwb_wr && (memwb_rd == idx)) r = memwb_res;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_id_ex_stage_if.sv
// Decode-side and execute-side signals of the ID/EX stage; master is the
// surrounding pipeline, slave is the stage itself.
interface mips_id_ex_stage_if;
  import mips_pkg::*;

  logic              id_valid;
  logic              id_ready;
  logic              flush;
  logic [1:0]        aluop;
  logic [5:0]        funct;
  logic [IDX_W-1:0]  rs_idx;
  logic [IDX_W-1:0]  rt_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  logic              alu_src;
  logic              exmem_wr;
  logic [IDX_W-1:0]  exmem_rd;
  logic [DATA_W-1:0] exmem_res;
  logic              memwb_wr;
  logic [IDX_W-1:0]  memwb_rd;
  logic [DATA_W-1:0] memwb_res;
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        alu_ctl;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] store_data;
  logic [IDX_W-1:0]  ex_rd;
  logic              illegal;

  modport master (
    output id_valid, flush, aluop, funct, rs_idx, rt_idx, rd_idx, rs_data, rt_data,
           imm, alu_src, exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res,
           ex_ready,
    input  id_ready, ex_valid, alu_ctl, a, b, store_data, ex_rd, illegal
  );

  modport slave (
    input  id_valid, flush, aluop, funct, rs_idx, rt_idx, rd_idx, rs_data, rt_data,
           imm, alu_src, exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res,
           ex_ready,
    output id_ready, ex_valid, alu_ctl, a, b, store_data, ex_rd, illegal
  );

endinterface

// File: rtl/mips_alu_ctl_dec.sv
// Combinational ALU control decode from aluop/funct; unknown R-type funct
// yields ALU_BAD and raises illegal.
module mips_alu_ctl_dec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       illegal
);

  always_comb begin
    alu_ctl = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM: alu_ctl = ALU_ADD;
      ALUOP_BR:  alu_ctl = ALU_SUB;
      ALUOP_ORI: alu_ctl = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          FN_NOR:  alu_ctl = ALU_NOR;
          default: begin
            alu_ctl = ALU_BAD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline stage: ALU control decode, operand forwarding, and the
// registered operand set presented to the ALU behind a valid/ready handshake.
module mips_id_ex_stage
  import mips_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  mips_id_ex_stage_if.slave bus
);

  logic [3:0]        dec_ctl;
  logic              dec_ill;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic              capture;

  logic              ex_valid_q, ex_valid_d;
  logic [3:0]        alu_ctl_q, alu_ctl_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [IDX_W-1:0]  ex_rd_q, ex_rd_d;
  logic              illegal_q, illegal_d;

  mips_alu_ctl_dec u_dec (
    .aluop   (bus.aluop),
    .funct   (bus.funct),
    .alu_ctl (dec_ctl),
    .illegal (dec_ill)
  );

  assign fwd_rs = fwd_operand(bus.rs_idx, bus.rs_data, bus.exmem_wr, bus.exmem_rd,
                              bus.exmem_res, bus.memwb_wr, bus.memwb_rd, bus.memwb_res);
  assign fwd_rt = fwd_operand(bus.rt_idx, bus.rt_data, bus.exmem_wr, bus.exmem_rd,
                              bus.exmem_res, bus.memwb_wr, bus.memwb_rd, bus.memwb_res);

  assign bus.id_ready = !ex_valid_q || bus.ex_ready;
  assign capture      = bus.id_valid && bus.id_ready && !bus.flush;

  // Flush only kills the valid bit; the data registers keep their contents.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    alu_ctl_d    = alu_ctl_q;
    a_d          = a_q;
    b_d          = b_q;
    store_data_d = store_data_q;
    ex_rd_d      = ex_rd_q;
    illegal_d    = illegal_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (capture) begin
      ex_valid_d   = 1'b1;
      alu_ctl_d    = dec_ctl;
      a_d          = fwd_rs;
      b_d          = bus.alu_src ? bus.imm : fwd_rt;
      store_data_d = fwd_rt;
      ex_rd_d      = bus.rd_idx;
      illegal_d    = dec_ill;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      alu_ctl_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      store_data_q <= '0;
      ex_rd_q      <= '0;
      illegal_q    <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      alu_ctl_q    <= alu_ctl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      store_data_q <= store_data_d;
      ex_rd_q      <= ex_rd_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.alu_ctl    = alu_ctl_q;
  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.store_data = store_data_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Bench for mips_id_ex_stage: directed scenarios plus random traffic checked
// against a behavioural model of the stage.
module tb_mips_id_ex_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mips_id_ex_stage_if bus ();

  mips_id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] fn_tab  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
  logic [3:0] ctl_tab [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd12};

  logic       m_valid;
  logic [3:0] m_ctl;
  logic [7:0] m_a, m_b, m_sd;
  logic [2:0] m_rd;
  logic       m_ill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_dec(input logic [1:0] op, input logic [5:0] fn,
                                  output logic [3:0] ctl, output logic ill);
    ill = 1'b0;
    ctl = 4'd2;
    if (op == 2'd1) ctl = 4'd6;
    else if (op == 2'd3) ctl = 4'd1;
    else if (op == 2'd2) begin
      ctl = 4'hF;
      ill = 1'b1;
      for (int i = 0; i < 6; i++)
        if (fn_tab[i] == fn) begin
          ctl = ctl_tab[i];
          ill = 1'b0;
        end
    end
  endfunction

  function automatic logic [7:0] ref_src(input logic [2:0] idx, input logic [7:0] rf);
    if (idx == 3'd0) return rf;
    if (bus.exmem_wr && bus.exmem_rd == idx) return bus.exmem_res;
    if (bus.memwb_wr && bus.memwb_rd == idx) return bus.memwb_res;
    return rf;
  endfunction

  task automatic model_edge();
    logic [7:0] rt_v;
    if (!rst_n) begin
      m_valid = 0; m_ctl = 0; m_a = 0; m_b = 0; m_sd = 0; m_rd = 0; m_ill = 0;
    end else if (bus.flush) begin
      m_valid = 0;
    end else if (bus.id_valid && (!m_valid || bus.ex_ready)) begin
      m_valid = 1;
      ref_dec(bus.aluop, bus.funct, m_ctl, m_ill);
      rt_v = ref_src(bus.rt_idx, bus.rt_data);
      m_a  = ref_src(bus.rs_idx, bus.rs_data);
      m_b  = bus.alu_src ? bus.imm : rt_v;
      m_sd = rt_v;
      m_rd = bus.rd_idx;
    end else if (bus.ex_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("alu_ctl", 32'(bus.alu_ctl), 32'(m_ctl));
    chk("a", 32'(bus.a), 32'(m_a));
    chk("b", 32'(bus.b), 32'(m_b));
    chk("store_data", 32'(bus.store_data), 32'(m_sd));
    chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
    chk("illegal", 32'(bus.illegal), 32'(m_ill));
  endtask

  // Inputs are set at posedge+1; id_ready checked mid-cycle, outputs at next posedge+1.
  task automatic step();
    #1;
    chk("id_ready", 32'(bus.id_ready), 32'(!m_valid || bus.ex_ready));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive_idle();
    rst_n         = 1'b1;
    bus.id_valid  = 0; bus.flush = 0; bus.aluop = 0; bus.funct = 0;
    bus.rs_idx    = 0; bus.rt_idx = 0; bus.rd_idx = 0;
    bus.rs_data   = 0; bus.rt_data = 0; bus.imm = 0; bus.alu_src = 0;
    bus.exmem_wr  = 0; bus.exmem_rd = 0; bus.exmem_res = 0;
    bus.memwb_wr  = 0; bus.memwb_rd = 0; bus.memwb_res = 0;
    bus.ex_ready  = 1;
  endtask

  logic [7:0] saved_a, saved_b;
  logic [3:0] saved_ctl;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid = 0; m_ctl = 0; m_a = 0; m_b = 0; m_sd = 0; m_rd = 0; m_ill = 0;
    drive_idle();

    rst_n = 1'b0;
    step();
    chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
    rst_n = 1'b1;

    // R-type AND, no forwarding
    bus.id_valid = 1; bus.aluop = 2'b10; bus.funct = 6'b100100;
    bus.rs_idx = 1; bus.rt_idx = 2; bus.rd_idx = 4;
    bus.rs_data = 8'hF0; bus.rt_data = 8'h3C;
    step();
    chk("and_valid", 32'(bus.ex_valid), 32'd1);
    chk("and_ctl", 32'(bus.alu_ctl), 32'h0);
    chk("and_a", 32'(bus.a), 32'hF0);
    chk("and_b", 32'(bus.b), 32'h3C);

    // Both stages write r3: EX/MEM wins
    bus.rs_idx = 3; bus.exmem_wr = 1; bus.exmem_rd = 3; bus.exmem_res = 8'h11;
    bus.memwb_wr = 1; bus.memwb_rd = 3; bus.memwb_res = 8'h22;
    step();
    chk("fwd_prio_a", 32'(bus.a), 32'h11);
    bus.rs_idx = 0; bus.rs_data = 8'h00; bus.exmem_rd = 0; bus.memwb_rd = 0;
    step();
    chk("fwd_r0_a", 32'(bus.a), 32'h00);
    bus.rs_data = 8'h5A;
    step();
    chk("fwd_r0_raw", 32'(bus.a), 32'h5A);

    // lw: imm operand, rt forwarded from MEM/WB
    bus.aluop = 2'b00; bus.alu_src = 1; bus.imm = 8'h04; bus.rs_idx = 1; bus.rs_data = 8'h10;
    bus.rt_idx = 5; bus.rt_data = 8'h99; bus.exmem_wr = 0;
    bus.memwb_wr = 1; bus.memwb_rd = 5; bus.memwb_res = 8'h55;
    step();
    chk("lw_ctl", 32'(bus.alu_ctl), 32'h2);
    chk("lw_b", 32'(bus.b), 32'h04);
    chk("lw_sd", 32'(bus.store_data), 32'h55);

    // Stall three cycles with a new instruction waiting
    saved_a = bus.a; saved_b = bus.b; saved_ctl = bus.alu_ctl;
    bus.ex_ready = 0; bus.aluop = 2'b01; bus.alu_src = 0; bus.memwb_wr = 0;
    bus.rs_idx = 1; bus.rs_data = 8'h77; bus.rt_idx = 2; bus.rt_data = 8'h07;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdy", 32'(bus.id_ready), 32'd0);
      chk("stall_a", 32'(bus.a), 32'(saved_a));
      chk("stall_b", 32'(bus.b), 32'(saved_b));
      chk("stall_ctl", 32'(bus.alu_ctl), 32'(saved_ctl));
    end
    bus.ex_ready = 1;
    #1;
    chk("unstall_rdy", 32'(bus.id_ready), 32'd1);
    step();
    chk("unstall_a", 32'(bus.a), 32'h77);
    chk("unstall_ctl", 32'(bus.alu_ctl), 32'h6);

    // Flush beats capture
    bus.flush = 1;
    step();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    bus.flush = 0; bus.aluop = 2'b10; bus.funct = 6'b111111;
    step();
    chk("bad_ctl", 32'(bus.alu_ctl), 32'hF);
    chk("bad_ill", 32'(bus.illegal), 32'd1);

    // Reset in the middle of a stall
    bus.ex_ready = 0; bus.funct = 6'b100000;
    step();
    rst_n = 0;
    step();
    chk("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_stall_ctl", 32'(bus.alu_ctl), 32'd0);
    chk("rst_stall_a", 32'(bus.a), 32'd0);
    chk("rst_stall_rdy", 32'(bus.id_ready), 32'd1);
    rst_n = 1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(49) != 0);
      bus.flush     = ($urandom_range(9) == 0);
      bus.id_valid  = ($urandom_range(3) != 0);
      bus.ex_ready  = ($urandom_range(9) < 7);
      bus.aluop     = 2'($urandom_range(3));
      bus.funct     = ($urandom_range(3) != 0) ? fn_tab[$urandom_range(5)] : 6'($urandom);
      bus.rs_idx    = 3'($urandom); bus.rt_idx = 3'($urandom); bus.rd_idx = 3'($urandom);
      bus.rs_data   = 8'($urandom); bus.rt_data = 8'($urandom); bus.imm = 8'($urandom);
      bus.alu_src   = 1'($urandom);
      bus.exmem_wr  = 1'($urandom); bus.exmem_rd = 3'($urandom); bus.exmem_res = 8'($urandom);
      bus.memwb_wr  = 1'($urandom); bus.memwb_rd = 3'($urandom); bus.memwb_res = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_id_ex_stage.md
# mips_id_ex_stage

Decode-to-execute pipeline stage that sits directly upstream of the 8-bit MIPS ALU. It decodes `aluop`/`funct` into the 4-bit ALU control code and resolves operand forwarding from the EX/MEM and MEM/WB stages. It then registers `alu_ctl`, `a` and `b` behind a valid/ready handshake, so the ALU sees stable, already-forwarded operands one cycle after decode.

## Interface
- Parameters: none. Fixed widths: data 8 bits, register index 3 bits (8 registers, r0 hard-wired zero).
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset.
- `id_valid` in 1: decode stage presents an instruction.
- `id_ready` out 1: stage can accept this cycle (combinational).
- `flush` in 1: squash the held instruction (branch taken).
- `aluop` in 2: 00 load/store add, 01 branch sub, 10 R-type, 11 ori.
- `funct` in 6: R-type function field.
- `rs_idx`, `rt_idx` in 3: source register indices.
- `rd_idx` in 3: destination index, passed through.
- `rs_data`, `rt_data` in 8: register-file read data.
- `imm` in 8: immediate, already sized.
- `alu_src` in 1: 1 selects `imm` for operand b.
- `exmem_wr` in 1, `exmem_rd` in 3, `exmem_res` in 8: EX/MEM forwarding source.
- `memwb_wr` in 1, `memwb_rd` in 3, `memwb_res` in 8: MEM/WB forwarding source.
- `ex_valid` out 1: registered outputs hold a live instruction.
- `ex_ready` in 1: execute stage consumes this cycle.
- `alu_ctl` out 4: registered ALU control code.
- `a`, `b` out 8: registered ALU operands.
- `store_data` out 8: registered forwarded rt value, used by sw.
- `ex_rd` out 3: registered destination index.
- `illegal` out 1: registered flag, R-type `funct` not recognised.

## Operation
- ALU control decode:
  - aluop 00 → 0010 (add).
  - aluop 01 → 0110 (sub).
  - aluop 11 → 0001 (or).
  - aluop 10 decodes `funct`: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111, 100111 → 1100. Any other value → 1111 with `illegal` = 1; the ALU then outputs 0.
- Forwarding, applied per source operand before registering:
  - If `exmem_wr` and `exmem_rd` == idx and idx != 0, use `exmem_res`.
  - Else if `memwb_wr` and `memwb_rd` == idx and idx != 0, use `memwb_res`.
  - Else use the register-file data.
  - EX/MEM has priority when both match.
  - Index 0 always yields the raw register-file data; it is never forwarded.
- Operand select: `a` = forwarded rs. `b` = `imm` if `alu_src`, else forwarded rt. `store_data` = forwarded rt regardless of `alu_src`.
- Handshake:
  - `id_ready` = !`ex_valid` || `ex_ready`.
  - Capture occurs when `id_valid` && `id_ready`.
  - If nothing is captured and `ex_ready`, then `ex_valid` clears.
  - While `ex_valid` && !`ex_ready` (stall), every registered output holds.
- Flush: `ex_valid` ← 0 next edge and nothing is captured that cycle, even if `id_valid`. Data registers hold. `id_ready` is still computed normally; the upstream stage must treat `flush` as also squashing its own instruction.

## Timing
- Latency: one cycle from capture edge to outputs.
- Throughput: one instruction per cycle when `ex_ready` is held high.
- Reset (`rst_n` = 0 at an edge):
  - `ex_valid` = 0, `alu_ctl` = 0000, `a` = `b` = `store_data` = 0, `ex_rd` = 0, `illegal` = 0.
  - Reset overrides `flush` and capture.
  - Reset mid-stall discards the held instruction.
- Priority order per edge: reset > flush > capture > drain.
- Forwarding inputs are sampled only at the capture edge. A stalled held instruction is not re-forwarded; the upstream hazard unit guarantees this is safe.

## Structure
- Shared package `mips_pkg`:
  - ALU control constants: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`, `ALU_BAD`.
  - `aluop` encodings.
  - `funct` encodings.
  - Data and index width constants.
- One combinational sub-module, `mips_alu_ctl_dec` (`aluop`, `funct` → `alu_ctl`, `illegal`), instantiated once. Forwarding muxes and pipeline registers are written inline.

## Test plan
- R-type and (aluop 10, funct 100100), rs_data 0xF0, rt_data 0x3C, no forwarding, `ex_ready` 1 → next cycle `ex_valid` 1, `alu_ctl` 0000, `a` 0xF0, `b` 0x3C.
- Both stages write r3 (`exmem_res` 0x11, `memwb_res` 0x22), `rs_idx` 3 → `a` 0x11. Repeat with `rs_idx` 0 and rs_data 0x00 → `a` 0x00.
- lw with `alu_src` 1, imm 0x04, rt forwarded 0x55 from MEM/WB → `alu_ctl` 0010, `b` 0x04, `store_data` 0x55.
- Hold `ex_ready` 0 for 3 cycles with a new `id_valid` → `id_ready` 0, outputs frozen. When `ex_ready` rises, `id_ready` 1 and the new instruction appears the next cycle.
- Assert `flush` together with `id_valid` → next cycle `ex_valid` 0. funct 111111 → `alu_ctl` 1111, `illegal` 1.
- Drive `rst_n` 0 during a stall → all outputs zero next edge, `id_ready` 1.
